// File: rtl/dmem_param.sv
// dmem_param: parametrised byte-addressable data memory with RISC-V load/store sizing,
// sign/zero extension and a registered read with valid strobe.
// Optional build macro DMEM_MISALIGN_TRAP_EN: misaligned accesses are suppressed and flagged
// on err instead of being forced to natural alignment.
module dmem_param #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 256,
    parameter int AW    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            RW,
    input  logic [AW-1:0]   addr,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] dataIN,
    output logic [XLEN-1:0] dataOUT,
    output logic            rvalid,
    output logic            err
);
    localparam int NB = XLEN / 8;
    localparam int LB = $clog2(NB);
    localparam int WB = $clog2(DEPTH);

    logic [XLEN-1:0] r_mem [DEPTH];
    logic [XLEN-1:0] r_dout;
    logic            r_rvalid;
    logic            r_err;

    logic [1:0]      w_size;
    logic [2:0]      w_lo;
    logic            w_mis;
    logic            w_ill;
    logic            w_bad;
    logic [WB-1:0]   w_idx;
    logic [LB-1:0]   w_lane;
    logic [7:0]      w_bm;
    logic [NB-1:0]   w_be;
    logic [XLEN-1:0] w_wdata;
    logic            w_we;
    logic            w_rd;
    logic [XLEN-1:0] w_sh;
    logic [6:0]      w_bits;
    logic [XLEN-1:0] w_keep;
    logic            w_top;
    logic            w_fill;
    logic [XLEN-1:0] w_load;
    logic            w_unused_addr;

    // Decode access size, alignment and legality of funct3.
    always_comb begin
        w_size = funct3[1:0];
        w_lo   = (w_size == 2'd0) ? 3'b000 : (w_size == 2'd1) ? 3'b001 : (w_size == 2'd2) ? 3'b011 : 3'b111;
        w_mis  = |(addr[2:0] & w_lo);
        w_ill  = (funct3 == 3'b111) || ((XLEN == 32) && ((funct3 == 3'b011) || (funct3 == 3'b110)));
`ifdef DMEM_MISALIGN_TRAP_EN
        w_bad  = w_ill | w_mis;
`else
        w_bad  = w_ill;
`endif
    end

    // Word index, lane (forced to natural alignment) and byte-enable mask.
    always_comb begin
        w_idx         = addr[WB+LB-1:LB];
        w_lane        = addr[LB-1:0] & ~w_lo[LB-1:0];
        w_bm          = (w_size == 2'd0) ? 8'h01 : (w_size == 2'd1) ? 8'h03 : (w_size == 2'd2) ? 8'h0F : 8'hFF;
        w_be          = NB'(w_bm) << w_lane;
        w_wdata       = dataIN << {w_lane, 3'b000};
        w_we          = en & RW & ~w_bad & ~rst;
        w_rd          = en & ~RW & ~w_bad;
        w_unused_addr = ^addr[AW-1:WB+LB];
    end

    // Load path: shift selected bytes down and extend from the top bit of the loaded size.
    always_comb begin
        w_sh   = r_mem[w_idx] >> {w_lane, 3'b000};
        w_bits = 7'd8 << w_size;
        w_keep = ~({XLEN{1'b1}} << w_bits);
        w_top  = (w_size == 2'd0) ? w_sh[7] : (w_size == 2'd1) ? w_sh[15] : (w_size == 2'd2) ? w_sh[31] : w_sh[XLEN-1];
        w_fill = ~funct3[2] & w_top;
        w_load = (w_sh & w_keep) | ({XLEN{w_fill}} & ~w_keep);
    end

    // Byte-masked store; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int i = 0; i < NB; i++) begin
                if (w_be[i]) r_mem[w_idx][i*8 +: 8] <= w_wdata[i*8 +: 8];
            end
        end
    end

    // Registered read result, valid strobe and one-cycle error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout   <= '0;
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= w_rd;
            r_err    <= en & w_bad;
            if (w_rd) r_dout <= w_load;
        end
    end

    assign dataOUT = r_dout;
    assign rvalid  = r_rvalid;
    assign err     = r_err;
endmodule

// File: tb/tb_dmem_param.sv
// tb_dmem_param: scoreboard-driven checks of dmem_param load/store, extension, wrap, errors and reset.
module tb_dmem_param;
    logic        clk;
    logic        rst;
    logic        en;
    logic        RW;
    logic [31:0] addr;
    logic [2:0]  funct3;
    logic [31:0] dataIN;
    logic [31:0] dataOUT;
    logic        rvalid;
    logic        err;

    int          checks;
    int          errors;
    logic [31:0] q_exp [$];
    logic [31:0] exp_d;
    logic [31:0] held;

    dmem_param #(.XLEN(32), .DEPTH(256), .AW(32)) dut (
        .clk(clk), .rst(rst), .en(en), .RW(RW), .addr(addr), .funct3(funct3),
        .dataIN(dataIN), .dataOUT(dataOUT), .rvalid(rvalid), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic drive(input logic e, input logic rw, input logic [31:0] a, input logic [2:0] f, input logic [31:0] d);
        en = e;
        RW = rw;
        addr = a;
        funct3 = f;
        dataIN = d;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (dataOUT !== 32'h0 || rvalid !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: dataOUT=%h rvalid=%b err=%b expected 0/0/0", dataOUT, rvalid, err);
        end
        #4 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_word;
        drive(1, 1, 32'h10, 3'b010, 32'hDEADBEEF);
        checks++;
        if (rvalid !== 1'b0 || dataOUT !== 32'h0) begin
            errors++;
            $display("FAIL sw_no_valid: rvalid=%b dataOUT=%h expected 0/00000000", rvalid, dataOUT);
        end
        q_exp.push_back(32'hDEADBEEF);
        drive(1, 0, 32'h10, 3'b010, 32'h0);
        exp_d = q_exp.pop_front();
        checks++;
        if (rvalid !== 1'b1 || dataOUT !== exp_d) begin
            errors++;
            $display("FAIL lw_word: rvalid=%b dataOUT=%h expected 1/%h", rvalid, dataOUT, exp_d);
        end
    endtask

    task automatic test_byte_ext;
        drive(1, 1, 32'h20, 3'b010, 32'h0);
        drive(1, 1, 32'h22, 3'b000, 32'hFFFFFF80);
        q_exp.push_back(32'hFFFFFF80);
        drive(1, 0, 32'h22, 3'b000, 32'h0);
        exp_d = q_exp.pop_front();
        checks++;
        if (rvalid !== 1'b1 || dataOUT !== exp_d) begin
            errors++;
            $display("FAIL lb_sign: rvalid=%b dataOUT=%h expected 1/%h", rvalid, dataOUT, exp_d);
        end
        q_exp.push_back(32'h00000080);
        drive(1, 0, 32'h22, 3'b100, 32'h0);
        exp_d = q_exp.pop_front();
        checks++;
        if (rvalid !== 1'b1 || dataOUT !== exp_d) begin
            errors++;
            $display("FAIL lbu_zero: rvalid=%b dataOUT=%h expected 1/%h", rvalid, dataOUT, exp_d);
        end
        q_exp.push_back(32'h00800000);
        drive(1, 0, 32'h20, 3'b010, 32'h0);
        exp_d = q_exp.pop_front();
        checks++;
        if (rvalid !== 1'b1 || dataOUT !== exp_d) begin
            errors++;
            $display("FAIL lw_after_sb: rvalid=%b dataOUT=%h expected 1/%h", rvalid, dataOUT, exp_d);
        end
    endtask

    task automatic test_half_wrap;
        drive(1, 1, 32'h402, 3'b001, 32'hABCD1234);
        q_exp.push_back(32'h00001234);
        drive(1, 0, 32'h002, 3'b101, 32'h0);
        exp_d = q_exp.pop_front();
        checks++;
        if (rvalid !== 1'b1 || dataOUT !== exp_d) begin
            errors++;
            $display("FAIL lhu_wrap: rvalid=%b dataOUT=%h expected 1/%h", rvalid, dataOUT, exp_d);
        end
        drive(1, 1, 32'h006, 3'b001, 32'h00008001);
        q_exp.push_back(32'hFFFF8001);
        drive(1, 0, 32'h006, 3'b001, 32'h0);
        exp_d = q_exp.pop_front();
        checks++;
        if (rvalid !== 1'b1 || dataOUT !== exp_d) begin
            errors++;
            $display("FAIL lh_sign: rvalid=%b dataOUT=%h expected 1/%h", rvalid, dataOUT, exp_d);
        end
    endtask

    task automatic test_misalign;
        held = dataOUT;
        drive(1, 0, 32'h13, 3'b010, 32'h0);
`ifdef DMEM_MISALIGN_TRAP_EN
        checks++;
        if (err !== 1'b1 || rvalid !== 1'b0 || dataOUT !== held) begin
            errors++;
            $display("FAIL misalign_trap: err=%b rvalid=%b dataOUT=%h expected 1/0/%h", err, rvalid, dataOUT, held);
        end
`else
        checks++;
        if (err !== 1'b0 || rvalid !== 1'b1 || dataOUT !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL misalign_force: err=%b rvalid=%b dataOUT=%h expected 0/1/deadbeef", err, rvalid, dataOUT);
        end
`endif
        drive(0, 0, 32'h0, 3'b010, 32'h0);
        checks++;
        if (err !== 1'b0 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL misalign_pulse_end: err=%b rvalid=%b expected 0/0", err, rvalid);
        end
    endtask

    task automatic test_illegal;
        drive(1, 1, 32'h10, 3'b111, 32'h0);
        checks++;
        if (err !== 1'b1 || rvalid !== 1'b0) begin
            errors++;
            $display("FAIL illegal_store: err=%b rvalid=%b expected 1/0", err, rvalid);
        end
        held = dataOUT;
        drive(1, 0, 32'h10, 3'b011, 32'h0);
        checks++;
        if (err !== 1'b1 || rvalid !== 1'b0 || dataOUT !== held) begin
            errors++;
            $display("FAIL illegal_ld32: err=%b rvalid=%b dataOUT=%h expected 1/0/%h", err, rvalid, dataOUT, held);
        end
        q_exp.push_back(32'hDEADBEEF);
        drive(1, 0, 32'h10, 3'b010, 32'h0);
        exp_d = q_exp.pop_front();
        checks++;
        if (err !== 1'b0 || rvalid !== 1'b1 || dataOUT !== exp_d) begin
            errors++;
            $display("FAIL illegal_no_write: err=%b rvalid=%b dataOUT=%h expected 0/1/%h", err, rvalid, dataOUT, exp_d);
        end
    endtask

    task automatic test_back_to_back;
        drive(1, 1, 32'h30, 3'b010, 32'hA5A5A5A5);
        q_exp.push_back(32'hA5A5A5A5);
        drive(1, 0, 32'h30, 3'b010, 32'h0);
        exp_d = q_exp.pop_front();
        checks++;
        if (rvalid !== 1'b1 || dataOUT !== exp_d) begin
            errors++;
            $display("FAIL b2b_read: rvalid=%b dataOUT=%h expected 1/%h", rvalid, dataOUT, exp_d);
        end
        for (int k = 0; k < 2; k++) begin
            drive(0, 0, 32'h0, 3'b010, 32'h0);
            checks++;
            if (rvalid !== 1'b0 || dataOUT !== 32'hA5A5A5A5) begin
                errors++;
                $display("FAIL idle_hold: cycle=%0d rvalid=%b dataOUT=%h expected 0/a5a5a5a5", k, rvalid, dataOUT);
            end
        end
    endtask

    task automatic test_stream;
        logic [31:0] a_list [3];
        a_list[0] = 32'h10;
        a_list[1] = 32'h30;
        a_list[2] = 32'h20;
        q_exp.push_back(32'hDEADBEEF);
        q_exp.push_back(32'hA5A5A5A5);
        q_exp.push_back(32'h00800000);
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, a_list[k], 3'b010, 32'h0);
            exp_d = q_exp.pop_front();
            checks++;
            if (rvalid !== 1'b1 || dataOUT !== exp_d) begin
                errors++;
                $display("FAIL stream_read: idx=%0d rvalid=%b dataOUT=%h expected 1/%h", k, rvalid, dataOUT, exp_d);
            end
        end
    endtask

    task automatic test_mid_read_reset;
        en = 1'b1;
        RW = 1'b0;
        addr = 32'h10;
        funct3 = 3'b010;
        @(posedge clk);
        #1 rst = 1'b1;
        en = 1'b0;
        #1;
        checks++;
        if (dataOUT !== 32'h0 || rvalid !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_read: dataOUT=%h rvalid=%b err=%b expected 0/0/0", dataOUT, rvalid, err);
        end
        #4 rst = 1'b0;
        drive(0, 0, 32'h0, 3'b010, 32'h0);
        checks++;
        if (rvalid !== 1'b0 || dataOUT !== 32'h0) begin
            errors++;
            $display("FAIL reset_release: rvalid=%b dataOUT=%h expected 0/00000000", rvalid, dataOUT);
        end
        q_exp.push_back(32'hA5A5A5A5);
        drive(1, 0, 32'h30, 3'b010, 32'h0);
        exp_d = q_exp.pop_front();
        checks++;
        if (rvalid !== 1'b1 || dataOUT !== exp_d) begin
            errors++;
            $display("FAIL mem_kept: rvalid=%b dataOUT=%h expected 1/%h", rvalid, dataOUT, exp_d);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        en = 1'b0;
        RW = 1'b0;
        addr = '0;
        funct3 = 3'b010;
        dataIN = '0;
        test_reset;
        test_word;
        test_byte_ext;
        test_half_wrap;
        test_misalign;
        test_illegal;
        test_back_to_back;
        test_stream;
        test_mid_read_reset;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
